// File: rtl/cpu_run_controller_pkg.sv
// Shared types and defaults for the CPU run controller.
// State encoding and parameter defaults live here.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } state_e;

  localparam int DEF_RESET_CYCLES = 10;
  localparam int DEF_MAX_CYCLES   = 1000;
  localparam int DEF_STALL_LIMIT  = 4;
  localparam int DEF_PC_W         = 32;
  localparam int DEF_CNT_W        = 32;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cpu_run_controller_if.sv
// Core-side control/status bundle of the run controller.
// master: core/bench side, slave: controller side.
interface cpu_run_controller_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic             restart;
  logic             halt_in;
  logic [PC_W-1:0]  pc;
  logic             pc_valid;
  logic             retire;
  logic             cpu_reset;
  logic             run_active;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;
  logic [PC_W-1:0]  final_pc;

  modport master (
    output restart, halt_in, pc,
    output pc_valid, retire,
    input  cpu_reset, run_active,
    input  done, timeout,
    input  cycle_count, instr_count,
    input  final_pc
  );

  modport slave (
    input  restart, halt_in, pc,
    input  pc_valid, retire,
    output cpu_reset, run_active,
    output done, timeout,
    output cycle_count, instr_count,
    output final_pc
  );
endinterface

// File: rtl/cpu_run_controller_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over enable.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/cpu_run_controller.sv
// Run controller: holds core reset, supervises the run,
// detects halt / branch-to-self and watchdog timeout.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int STALL_LIMIT  = DEF_STALL_LIMIT,
  parameter int PC_W         = DEF_PC_W,
  parameter int CNT_W        = DEF_CNT_W
) (
  input logic           clock,
  input logic           reset,
  cpu_run_controller_if.slave bus
);
  localparam int HW = cnt_w(RESET_CYCLES);
  localparam int SW = cnt_w(STALL_LIMIT);

  state_e          r_state;
  logic [PC_W-1:0] r_last_pc;
  logic [PC_W-1:0] r_final_pc;

  logic [HW-1:0]    w_hold;
  logic [SW-1:0]    w_stall;
  logic [CNT_W-1:0] w_cycle;
  logic [CNT_W-1:0] w_instr;
  logic w_in_hold;
  logic w_in_run;
  logic w_restart;
  logic w_pc_eq;
  logic w_pc_new;
  logic w_hold_end;
  logic w_stall_hit;
  logic w_wdog;

  assign w_in_hold = (r_state == HOLD);
  assign w_in_run  = (r_state == RUN);
  assign w_restart = bus.restart &&
                     ((r_state == DONE) ||
                      (r_state == TIMEOUT));
  assign w_pc_eq   = bus.pc_valid &&
                     (bus.pc == r_last_pc);
  assign w_pc_new  = bus.pc_valid &&
                     (bus.pc != r_last_pc);

  assign w_hold_end  = (w_hold == HW'(RESET_CYCLES - 1));
  // counter value before this cycle's increment
  assign w_stall_hit = w_pc_eq &&
                       (w_stall == SW'(STALL_LIMIT - 2));
  assign w_wdog      = (w_cycle == CNT_W'(MAX_CYCLES - 1));

  sat_counter #(.W(HW)) u_hold (
    .i_clk (clock),
    .i_rst (reset),
    .i_en  (w_in_hold),
    .i_clr (w_restart),
    .o_q   (w_hold)
  );

  sat_counter #(.W(SW)) u_stall (
    .i_clk (clock),
    .i_rst (reset),
    .i_en  (w_in_run && w_pc_eq),
    .i_clr (w_restart || (w_in_run && w_pc_new)),
    .o_q   (w_stall)
  );

  sat_counter #(.W(CNT_W)) u_cycle (
    .i_clk (clock),
    .i_rst (reset),
    .i_en  (w_in_run),
    .i_clr (w_restart),
    .o_q   (w_cycle)
  );

  sat_counter #(.W(CNT_W)) u_instr (
    .i_clk (clock),
    .i_rst (reset),
    .i_en  (w_in_run && bus.retire),
    .i_clr (w_restart),
    .o_q   (w_instr)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= HOLD;
      r_last_pc  <= '0;
      r_final_pc <= '0;
    end else begin
      case (r_state)
        HOLD: begin
          if (w_hold_end) r_state <= RUN;
        end
        RUN: begin
          if (w_pc_new) r_last_pc <= bus.pc;
          if (bus.halt_in || w_stall_hit) begin
            r_state    <= DONE;
            r_final_pc <= bus.pc;
          end else if (w_wdog) begin
            r_state    <= TIMEOUT;
            r_final_pc <= r_last_pc;
          end
        end
        DONE, TIMEOUT: begin
          if (bus.restart) begin
            r_state   <= HOLD;
            r_last_pc <= '0;
          end
        end
        default: r_state <= HOLD;
      endcase
    end
  end

  assign bus.cpu_reset   = (r_state != RUN);
  assign bus.run_active  = (r_state == RUN);
  assign bus.done        = (r_state == DONE);
  assign bus.timeout     = (r_state == TIMEOUT);
  assign bus.cycle_count = w_cycle;
  assign bus.instr_count = w_instr;
  assign bus.final_pc    = r_final_pc;
endmodule

// File: tb/tb_cpu_run_controller.sv
// Randomised bench for cpu_run_controller against an
// abstract run model (phase flags, streak length, counts).
module tb_cpu_run_controller;
  localparam int RC = 10;
  localparam int MC = 50;
  localparam int SL = 4;
  localparam int PW = 32;
  localparam int CW = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;

  cpu_run_controller_if #(.PC_W(PW), .CNT_W(CW)) bus ();

  cpu_run_controller #(
    .RESET_CYCLES (RC),
    .MAX_CYCLES   (MC),
    .STALL_LIMIT  (SL),
    .PC_W         (PW),
    .CNT_W        (CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int          m_hold_left;
  bit          m_run, m_done, m_to;
  logic [CW-1:0] m_cyc, m_ins;
  logic [PW-1:0] m_final, m_spc;
  int          m_slen;
  logic [PW-1:0] pcseq = 32'h1000;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  task automatic model_restart();
    m_hold_left = RC;
    m_run = 0; m_done = 0; m_to = 0;
    m_cyc = '0; m_ins = '0;
    m_spc = '0; m_slen = 1;
  endtask

  task automatic model_reset();
    model_restart();
    m_final = '0;
  endtask

  task automatic model_edge();
    logic [PW-1:0] old_spc;
    int old_cyc;
    bit stalled;
    old_spc = m_spc;
    old_cyc = int'(m_cyc);
    stalled = 0;
    if (reset) begin
      model_reset();
    end else if (!m_run && !m_done && !m_to) begin
      if (m_hold_left <= 1) m_run = 1;
      else m_hold_left--;
    end else if (m_run) begin
      m_cyc = sat_inc(m_cyc);
      if (bus.retire) m_ins = sat_inc(m_ins);
      if (bus.pc_valid) begin
        if (bus.pc == m_spc) begin
          m_slen++;
          stalled = (m_slen >= SL);
        end else begin
          m_spc = bus.pc;
          m_slen = 1;
        end
      end
      if (bus.halt_in || stalled) begin
        m_run = 0; m_done = 1; m_final = bus.pc;
      end else if (old_cyc + 1 == MC) begin
        m_run = 0; m_to = 1; m_final = old_spc;
      end
    end else if (bus.restart) begin
      model_restart();
    end
  endtask

  task automatic check_all();
    chk("cpu_reset", bus.cpu_reset, !m_run);
    chk("run_active", bus.run_active, m_run);
    chk("done", bus.done, m_done);
    chk("timeout", bus.timeout, m_to);
    chk("cycle_count", bus.cycle_count, m_cyc);
    chk("instr_count", bus.instr_count, m_ins);
    chk("final_pc", bus.final_pc, m_final);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_in(input logic r, input logic h,
                        input logic [PW-1:0] p,
                        input logic v, input logic t);
    bus.restart  = r;
    bus.halt_in  = h;
    bus.pc       = p;
    bus.pc_valid = v;
    bus.retire   = t;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic next_pc();
    pcseq = pcseq + 32'd4;
  endtask

  task automatic do_restart();
    set_in(1, 0, pcseq, 0, 0);
    cycle();
    set_in(0, 0, pcseq, 0, 0);
    repeat (RC) cycle();
  endtask

  initial begin
    int n;
    logic [PW-1:0] rpc;
    set_in(0, 0, '0, 0, 0);
    model_reset();
    #1 reset = 1'b1;
    #1 check_all();
    repeat (2) cycle();
    reset = 1'b0;

    repeat (RC - 1) cycle();
    chk("hold_last_edge", bus.cpu_reset, 1);
    cycle();
    chk("run_start", bus.run_active, 1);

    for (int i = 1; i <= 20; i++) begin
      next_pc();
      set_in(0, i == 20, (i == 20) ? 32'h40 : pcseq,
             (i == 20) ? 1'b1 : rbit(), (i % 2) == 0);
      cycle();
      if (i == 1) chk("first_count", bus.cycle_count, 1);
    end
    chk("halt_done", bus.done, 1);
    chk("halt_pc", bus.final_pc, 32'h40);
    chk("halt_instr", bus.instr_count, 10);
    chk("halt_cycles", bus.cycle_count, 20);

    repeat (3) begin
      set_in(0, rbit(), pcseq, rbit(), rbit());
      cycle();
    end
    chk("done_frozen", bus.cycle_count, 20);

    set_in(1, 0, pcseq, 0, 0);
    cycle();
    chk("restart_cyc", bus.cycle_count, 0);
    chk("restart_fpc", bus.final_pc, 32'h40);
    for (int i = 0; i < RC; i++) begin
      set_in(i == 3, rbit(), pcseq, rbit(), rbit());
      cycle();
    end
    chk("rerun", bus.run_active, 1);

    repeat (6) begin
      next_pc();
      set_in(0, 0, pcseq, 1, rbit());
      cycle();
    end
    n = 0;
    while (!bus.done && n < 20) begin
      set_in(0, 0, 32'h80, 1, rbit());
      cycle();
      n++;
    end
    chk("stall_len", n, SL);
    chk("stall_pc", bus.final_pc, 32'h80);
    chk("stall_to", bus.timeout, 0);

    do_restart();
    for (int i = 1; i <= MC; i++) begin
      next_pc();
      set_in(i == 5, 0, pcseq, rbit(), rbit());
      cycle();
    end
    chk("wdog_to", bus.timeout, 1);
    chk("wdog_done", bus.done, 0);
    chk("wdog_cyc", bus.cycle_count, MC);

    do_restart();
    for (int i = 1; i <= MC; i++) begin
      next_pc();
      set_in(0, i == MC, pcseq, rbit(), rbit());
      cycle();
    end
    chk("race_done", bus.done, 1);
    chk("race_to", bus.timeout, 0);
    chk("race_cyc", bus.cycle_count, MC);

    do_restart();
    for (int i = 1; i <= 16; i++) begin
      next_pc();
      set_in(0, 0, pcseq, rbit(), rbit());
      cycle();
    end
    #2 reset = 1'b1;
    model_reset();
    #1 check_all();
    chk("async_cyc", bus.cycle_count, 0);
    cycle();
    reset = 1'b0;
    repeat (RC) cycle();

    rpc = 32'h200;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(3, 0) == 0)
        rpc = 32'h200 + 32'($urandom_range(3, 0)) * 4;
      set_in((m_done || m_to) ? rbit() : rbit() & rbit(),
             $urandom_range(31, 0) == 0, rpc,
             $urandom_range(3, 0) != 0, rbit());
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
